// File: rtl/threshold_pkg.sv
// threshold_pkg: FVH bit positions and FSM state encoding shared by threshold_peak.
package threshold_pkg;
    localparam int FVH_F = 2;
    localparam int FVH_V = 1;
    localparam int FVH_H = 0;
    typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;
endpackage

// File: rtl/threshold_peak_if.sv
// threshold_peak_if: pixel stream, thresholds and per-line peak report bundle.
interface threshold_peak_if #(
    parameter int DW = 8,
    parameter int COLW = 10
);
    logic [DW-1:0]   thr_hi, thr_lo, din, dout, peak_val;
    logic [2:0]      fvh_in, fvh_out;
    logic            dv_in, dv_out, peak_found, peak_valid;
    logic [COLW-1:0] peak_col;
    modport master (
        output thr_hi, thr_lo, fvh_in, dv_in, din,
        input  fvh_out, dv_out, dout, peak_col, peak_val, peak_found, peak_valid
    );
    modport slave (
        input  thr_hi, thr_lo, fvh_in, dv_in, din,
        output fvh_out, dv_out, dout, peak_col, peak_val, peak_found, peak_valid
    );
endinterface

// File: rtl/line_peak_tracker.sv
// line_peak_tracker: saturating column counter plus max/argmax of "on" pixels; capture publishes the line result.
module line_peak_tracker #(
    parameter int DW = 8,
    parameter int COLW = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            en,
    input  logic            hit,
    input  logic            capture,
    input  logic [DW-1:0]   din,
    output logic [COLW-1:0] peak_col,
    output logic [DW-1:0]   peak_val,
    output logic            peak_found,
    output logic            peak_valid
);
    logic [COLW-1:0] col_q, col_d, arg_q, arg_d, cur, arg_base, peak_col_q, peak_col_d;
    logic [DW-1:0]   max_q, max_d, max_base, peak_val_q, peak_val_d;
    logic            found_q, found_d, found_base, take;
    logic            peak_found_q, peak_found_d, peak_valid_q, peak_valid_d;

    // clr marks the first pixel of a line, so it sees an empty tracker at column 0
    always_comb begin
        cur = clr ? '0 : col_q;
        arg_base = clr ? '0 : arg_q;
        max_base = clr ? '0 : max_q;
        found_base = clr ? 1'b0 : found_q;
        take = en && hit && (!found_base || din > max_base);
        col_d = en ? ((&cur) ? cur : cur + COLW'(1)) : col_q;
        arg_d = take ? cur : arg_base;
        max_d = take ? din : max_base;
        found_d = take || found_base;
        peak_col_d = capture ? arg_q : peak_col_q;
        peak_val_d = capture ? max_q : peak_val_q;
        peak_found_d = capture ? found_q : peak_found_q;
        peak_valid_d = capture;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q <= '0;
            arg_q <= '0;
            max_q <= '0;
            found_q <= 1'b0;
            peak_col_q <= '0;
            peak_val_q <= '0;
            peak_found_q <= 1'b0;
            peak_valid_q <= 1'b0;
        end else begin
            col_q <= col_d;
            arg_q <= arg_d;
            max_q <= max_d;
            found_q <= found_d;
            peak_col_q <= peak_col_d;
            peak_val_q <= peak_val_d;
            peak_found_q <= peak_found_d;
            peak_valid_q <= peak_valid_d;
        end
    end

    assign peak_col = peak_col_q;
    assign peak_val = peak_val_q;
    assign peak_found = peak_found_q;
    assign peak_valid = peak_valid_q;
endmodule

// File: rtl/threshold_peak.sv
// threshold_peak: 1-cycle pixel binariser with a per-line brightest "on" pixel report.
// Define THRESH_HYSTERESIS_EN to add an on/off hysteresis band using thr_lo.
module threshold_peak #(
    parameter int DW = 8,
    parameter int COLW = 10
) (
    input logic clk,
    input logic reset,
    threshold_peak_if.slave bus
);
    import threshold_pkg::*;

    state_t        state_q, state_d;
    logic [DW-1:0] thr_hi_q, thr_hi_d, hi, dout_q, dout_d;
    logic [2:0]    fvh_q, fvh_d;
    logic          dv_q, dv_d, idle, active, blank, line_pix, on, clr, capture;

    assign idle = state_q == IDLE;
    assign active = bus.dv_in && !bus.fvh_in[FVH_V] && !bus.fvh_in[FVH_H];
    assign blank = bus.fvh_in[FVH_V] || bus.fvh_in[FVH_H];
    assign line_pix = active && state_q != REPORT;
    // The first pixel of a line is judged against the live ports being latched alongside it
    assign hi = idle ? bus.thr_hi : thr_hi_q;

`ifdef THRESH_HYSTERESIS_EN
    logic [DW-1:0] thr_lo_q, thr_lo_d, lo;
    logic          hyst_q, hyst_d;
    assign lo = idle ? bus.thr_lo : thr_lo_q;
    assign on = (bus.din > hi) || (bus.din >= lo && state_q == ACTIVE && hyst_q);
    always_comb begin
        thr_lo_d = lo;
        hyst_d = line_pix ? on : hyst_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_lo_q <= '0;
            hyst_q <= 1'b0;
        end else begin
            thr_lo_q <= thr_lo_d;
            hyst_q <= hyst_d;
        end
    end
`else
    assign on = bus.din > hi;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = (idle && active) ? ACTIVE :
                  (state_q == ACTIVE && blank) ? REPORT :
                  (state_q == REPORT) ? IDLE : state_q;
    end

    always_comb begin
        clr = idle && active;
        capture = state_q == ACTIVE && blank;
        thr_hi_d = hi;
        dout_d = {DW{active && on}};
        fvh_d = bus.fvh_in;
        dv_d = bus.dv_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_hi_q <= '0;
            dout_q <= '0;
            fvh_q <= '0;
            dv_q <= 1'b0;
        end else begin
            thr_hi_q <= thr_hi_d;
            dout_q <= dout_d;
            fvh_q <= fvh_d;
            dv_q <= dv_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.fvh_out = fvh_q;
    assign bus.dv_out = dv_q;

    line_peak_tracker #(.DW(DW), .COLW(COLW)) u_tracker (
        .clk(clk),
        .reset(reset),
        .clr(clr),
        .en(line_pix),
        .hit(on),
        .capture(capture),
        .din(bus.din),
        .peak_col(bus.peak_col),
        .peak_val(bus.peak_val),
        .peak_found(bus.peak_found),
        .peak_valid(bus.peak_valid)
    );
endmodule

// File: tb/tb_threshold_peak.sv
// tb_threshold_peak: randomized line stimulus on two instances (COLW=10 and COLW=3) checked against a line-level model.
module tb_threshold_peak;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] thr_hi = '0, thr_lo = '0, din = '0;
    logic [2:0] fvh = 3'b011;
    logic       dv = 1'b0;
    int         checks = 0, failures = 0;
    int         px[64];
    int         n;
    logic [7:0] got0[$], got1[$];
    int         pv0, pv1;
    logic [9:0] col0;
    logic [2:0] col1;
    logic [7:0] val0, val1;
    logic       fnd0, fnd1;

    threshold_peak_if #(.DW(8), .COLW(10)) b0();
    threshold_peak_if #(.DW(8), .COLW(3)) b1();
    assign b0.thr_hi = thr_hi;
    assign b0.thr_lo = thr_lo;
    assign b0.fvh_in = fvh;
    assign b0.dv_in = dv;
    assign b0.din = din;
    assign b1.thr_hi = thr_hi;
    assign b1.thr_lo = thr_lo;
    assign b1.fvh_in = fvh;
    assign b1.dv_in = dv;
    assign b1.din = din;

    threshold_peak #(.DW(8), .COLW(10)) u0 (.clk(clk), .reset(reset), .bus(b0));
    threshold_peak #(.DW(8), .COLW(3)) u1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        if (b0.dv_out && b0.fvh_out[1:0] == 2'b00) got0.push_back(b0.dout);
        if (b1.dv_out && b1.fvh_out[1:0] == 2'b00) got1.push_back(b1.dout);
        if (b0.peak_valid) begin
            pv0++;
            col0 = b0.peak_col;
            val0 = b0.peak_val;
            fnd0 = b0.peak_found;
        end
        if (b1.peak_valid) begin
            pv1++;
            col1 = b1.peak_col;
            val1 = b1.peak_val;
            fnd1 = b1.peak_found;
        end
    endtask

    task automatic drive_line(input int hi_a, input int hi_b, input int sw, input int lo, input bit stalls);
        thr_hi = 8'(hi_a);
        thr_lo = 8'(lo);
        fvh = 3'b001;
        dv = 1'b1;
        repeat (3) cycle();
        got0.delete();
        got1.delete();
        pv0 = 0;
        pv1 = 0;
        for (int i = 0; i < n; i++) begin
            if (stalls && $urandom_range(3) == 0) begin
                dv = 1'b0;
                fvh = {1'($urandom), 2'b00};
                din = 8'($urandom);
                cycle();
            end
            if (i == sw) thr_hi = 8'(hi_b);
            dv = 1'b1;
            fvh = {1'($urandom), 2'b00};
            din = 8'(px[i]);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            fvh = {1'($urandom), 1'($urandom), 1'b1};
            dv = 1'($urandom);
            din = 8'($urandom);
            cycle();
        end
    endtask

    task automatic check_line(input int hi, input int lo, input string tag);
        int st, best, bi, ec0, ec1;
        logic [7:0] e;
        st = 0;
        best = -1;
        bi = 0;
        checks++;
        if (got0.size() != n || got1.size() != n) begin
            failures++;
            $display("FAIL %s pixel_count got=%0d/%0d exp=%0d", tag, got0.size(), got1.size(), n);
        end
        for (int i = 0; i < n; i++) begin
`ifdef THRESH_HYSTERESIS_EN
            if (px[i] > hi) st = 1;
            else if (px[i] < lo) st = 0;
`else
            st = (px[i] > hi) ? 1 : 0;
`endif
            e = (st != 0) ? 8'hFF : 8'h00;
            if (st != 0 && px[i] > best) begin
                best = px[i];
                bi = i;
            end
            if (i < got0.size() && i < got1.size()) begin
                checks++;
                if (got0[i] !== e || got1[i] !== e) begin
                    failures++;
                    $display("FAIL %s dout[%0d] got=%h/%h exp=%h", tag, i, got0[i], got1[i], e);
                end
            end
        end
        ec0 = (best < 0) ? 0 : (bi > 1023 ? 1023 : bi);
        ec1 = (best < 0) ? 0 : (bi > 7 ? 7 : bi);
        checks++;
        if (pv0 != 1 || pv1 != 1) begin
            failures++;
            $display("FAIL %s peak_valid_pulses got=%0d/%0d exp=1", tag, pv0, pv1);
        end
        checks++;
        if (fnd0 !== (best >= 0) || fnd1 !== (best >= 0)) begin
            failures++;
            $display("FAIL %s peak_found got=%b/%b exp=%b", tag, fnd0, fnd1, best >= 0);
        end
        checks++;
        if (val0 !== 8'((best < 0) ? 0 : best) || val1 !== 8'((best < 0) ? 0 : best)) begin
            failures++;
            $display("FAIL %s peak_val got=%0d/%0d exp=%0d", tag, val0, val1, (best < 0) ? 0 : best);
        end
        checks++;
        if (col0 !== 10'(ec0) || col1 !== 3'(ec1)) begin
            failures++;
            $display("FAIL %s peak_col got=%0d/%0d exp=%0d/%0d", tag, col0, col1, ec0, ec1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) cycle();
        checks++;
        if ({b0.dout, b0.dv_out, b0.fvh_out} !== '0 || {b1.dout, b1.dv_out, b1.fvh_out} !== '0) begin
            failures++;
            $display("FAIL reset_pixel_path got=%h/%h exp=0", {b0.dout, b0.dv_out, b0.fvh_out}, {b1.dout, b1.dv_out, b1.fvh_out});
        end
        checks++;
        if ({b0.peak_col, b0.peak_val, b0.peak_found, b0.peak_valid} !== '0 ||
            {b1.peak_col, b1.peak_val, b1.peak_found, b1.peak_valid} !== '0) begin
            failures++;
            $display("FAIL reset_peak got=%h/%h exp=0", {b0.peak_col, b0.peak_val, b0.peak_found, b0.peak_valid},
                     {b1.peak_col, b1.peak_val, b1.peak_found, b1.peak_valid});
        end
        reset = 1'b0;
        fvh = 3'b001;
        dv = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_basic();
        n = 6;
        px[0] = 10; px[1] = 200; px[2] = 50; px[3] = 220; px[4] = 220; px[5] = 5;
        drive_line(100, 100, -1, 0, 1'b0);
        check_line(100, 0, "basic");
    endtask

    task automatic test_hysteresis();
        n = 4;
        px[0] = 120; px[1] = 60; px[2] = 30; px[3] = 60;
        drive_line(100, 100, -1, 40, 1'b0);
        check_line(100, 40, "hysteresis");
    endtask

    task automatic test_no_peak();
        n = 8;
        for (int i = 0; i < n; i++) px[i] = 20;
        drive_line(100, 100, -1, 0, 1'b1);
        check_line(100, 0, "no_peak");
    endtask

    task automatic test_thr_change();
        n = 10;
        for (int i = 0; i < n; i++) px[i] = $urandom_range(5, 150);
        px[6] = 60;
        drive_line(100, 10, 4, 0, 1'b1);
        check_line(100, 0, "thr_midline");
        for (int i = 0; i < n; i++) px[i] = $urandom_range(5, 150);
        drive_line(10, 10, -1, 0, 1'b1);
        check_line(10, 0, "thr_nextline");
    endtask

    task automatic test_saturation();
        n = 12;
        for (int i = 0; i < n; i++) px[i] = $urandom_range(101, 200);
        px[10] = 250;
        drive_line(100, 100, -1, 0, 1'b1);
        check_line(100, 0, "saturation");
    endtask

    task automatic test_all_ones();
        n = 10;
        for (int i = 0; i < n; i++) px[i] = $urandom_range(0, 255);
        px[3] = 255;
        drive_line(255, 255, -1, 0, 1'b0);
        check_line(255, 0, "thr_all_ones");
    endtask

    task automatic test_reset_midline();
        thr_hi = 8'd50;
        fvh = 3'b001;
        dv = 1'b1;
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) begin
            fvh = 3'b000;
            din = 8'd200;
            cycle();
        end
        din = 8'd210;
        reset = 1'b1;
        #1;
        checks++;
        if ({b0.dout, b0.dv_out, b0.fvh_out, b0.peak_col, b0.peak_val, b0.peak_found, b0.peak_valid} !== '0 ||
            {b1.dout, b1.dv_out, b1.fvh_out, b1.peak_col, b1.peak_val, b1.peak_found, b1.peak_valid} !== '0) begin
            failures++;
            $display("FAIL reset_midline_outputs got=%h/%h exp=0",
                     {b0.dout, b0.dv_out, b0.fvh_out, b0.peak_col, b0.peak_val, b0.peak_found, b0.peak_valid},
                     {b1.dout, b1.dv_out, b1.fvh_out, b1.peak_col, b1.peak_val, b1.peak_found, b1.peak_valid});
        end
        pv0 = 0;
        pv1 = 0;
        cycle();
        reset = 1'b0;
        fvh = 3'b001;
        repeat (5) cycle();
        checks++;
        if (pv0 != 0 || pv1 != 0) begin
            failures++;
            $display("FAIL reset_midline_no_report got=%0d/%0d exp=0", pv0, pv1);
        end
        n = 8;
        for (int i = 0; i < n; i++) px[i] = $urandom_range(0, 255);
        drive_line(90, 90, -1, 30, 1'b1);
        check_line(90, 30, "after_reset");
    endtask

    task automatic test_random();
        int hi, lo;
        for (int k = 0; k < 25; k++) begin
            n = $urandom_range(1, 40);
            hi = $urandom_range(0, 254);
            lo = $urandom_range(0, hi);
            for (int i = 0; i < n; i++) px[i] = $urandom_range(0, 255);
            drive_line(hi, hi, -1, lo, 1'b1);
            check_line(hi, lo, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hysteresis();
        test_no_peak();
        test_thr_change();
        test_saturation();
        test_all_ones();
        test_basic();
        test_reset_midline();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
